// File: rtl/cereal_rx.sv
// 8N1 serial receiver: 2-flop synchroniser, mid-bit sampling FSM, one-cycle
// valid/frame_err strobes and a wrapping count of good bytes.
module cereal_rx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int CNT_W        = 13
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] byte_count
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  localparam logic [CNT_W-1:0] BIT_END = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] MID_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

  state_t           state_q, state_d;
  logic [1:0]       sync_q;
  logic [1:0]       warm_q;
  logic             armed_q;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             rxs;

  assign rxs = sync_q[1];

  // The synchroniser resets high, so arming waits until it has been refilled
  // from the pin and shows a genuine high level; a line held low across reset
  // is then ignored exactly as in BREAK.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      warm_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      warm_q  <= {warm_q[0], 1'b1};
      armed_q <= armed_q | (warm_q[1] & rxs);
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (armed_q && !rxs) state_d = START;
      end
      START: begin
        if (timer_q == MID_END) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer_q == BIT_END) begin
          timer_d = '0;
          shift_d = {rxs, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (timer_q == BIT_END) begin
          timer_d = '0;
          if (rxs) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            cnt_d   = cnt_q + 8'd1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        timer_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != IDLE);
  assign byte_count = cnt_q;

endmodule
